// File: rtl/alu_mdu.sv
// rtl/alu_mdu.sv - ALU with iterative multiply/divide unit behind a valid/ready handshake
// Single-cycle ops finish on the accepting edge; MUL/DIV variants take DATA_WIDTH busy cycles.
module alu_mdu #(
    parameter int DATA_WIDTH    = 32,
    parameter int OPCODE_LENGTH = 5
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [DATA_WIDTH-1:0]    SrcA,
    input  logic [DATA_WIDTH-1:0]    SrcB,
    input  logic [OPCODE_LENGTH-1:0] Operation,
    input  logic                     in_valid,
    output logic                     in_ready,
    output logic [DATA_WIDTH-1:0]    ALUResult,
    output logic                     Zero,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy
);
    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH + 1);

    localparam logic [OPCODE_LENGTH-1:0] OP_AND   = OPCODE_LENGTH'(5'b00000);
    localparam logic [OPCODE_LENGTH-1:0] OP_OR    = OPCODE_LENGTH'(5'b00001);
    localparam logic [OPCODE_LENGTH-1:0] OP_ADD   = OPCODE_LENGTH'(5'b00010);
    localparam logic [OPCODE_LENGTH-1:0] OP_SUB   = OPCODE_LENGTH'(5'b00011);
    localparam logic [OPCODE_LENGTH-1:0] OP_EQ    = OPCODE_LENGTH'(5'b01000);
    localparam logic [OPCODE_LENGTH-1:0] OP_XOR   = OPCODE_LENGTH'(5'b01001);
    localparam logic [OPCODE_LENGTH-1:0] OP_SLT   = OPCODE_LENGTH'(5'b01100);
    localparam logic [OPCODE_LENGTH-1:0] OP_SLTU  = OPCODE_LENGTH'(5'b01101);
    localparam logic [OPCODE_LENGTH-1:0] OP_MUL   = OPCODE_LENGTH'(5'b10000);
    localparam logic [OPCODE_LENGTH-1:0] OP_MULH  = OPCODE_LENGTH'(5'b10001);
    localparam logic [OPCODE_LENGTH-1:0] OP_MULHU = OPCODE_LENGTH'(5'b10010);
    localparam logic [OPCODE_LENGTH-1:0] OP_DIV   = OPCODE_LENGTH'(5'b10100);
    localparam logic [OPCODE_LENGTH-1:0] OP_DIVU  = OPCODE_LENGTH'(5'b10101);
    localparam logic [OPCODE_LENGTH-1:0] OP_REM   = OPCODE_LENGTH'(5'b10110);
    localparam logic [OPCODE_LENGTH-1:0] OP_REMU  = OPCODE_LENGTH'(5'b10111);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t                   state_q, state_d;
    logic [W-1:0]             result_q, result_d;
    logic [CW-1:0]            cnt_q, cnt_d;
    logic [OPCODE_LENGTH-1:0] op_q, op_d;
    logic [W-1:0]             mcand_q, mcand_d;   // multiplicand or divisor magnitude
    logic [W-1:0]             hi_q, hi_d;         // product high half or partial remainder
    logic [W-1:0]             lo_q, lo_d;         // multiplier bits or quotient bits
    logic [W-1:0]             src_a_q, src_a_d;
    logic                     neg_quo_q, neg_quo_d;
    logic                     neg_rem_q, neg_rem_d;
    logic                     dz_q, dz_d;

    logic [W-1:0]   alu_res, mag_a, mag_b, final_res, hi_n, lo_n, diff, quo_fix, rem_fix;
    logic [W:0]     sum, shifted;
    logic [2*W-1:0] prod, prod_fix;
    logic           is_multi, signed_op, sign_a, sign_b, ge;

    always_comb begin
        alu_res  = '0;
        is_multi = 1'b0;
        case (Operation)
            OP_AND:  alu_res = SrcA & SrcB;
            OP_OR:   alu_res = SrcA | SrcB;
            OP_ADD:  alu_res = SrcA + SrcB;
            OP_SUB:  alu_res = SrcA - SrcB;
            OP_EQ:   alu_res = {{(W-1){1'b0}}, SrcA == SrcB};
            OP_XOR:  alu_res = SrcA ^ SrcB;
            OP_SLT:  alu_res = {{(W-1){1'b0}}, $signed(SrcA) < $signed(SrcB)};
            OP_SLTU: alu_res = {{(W-1){1'b0}}, SrcA < SrcB};
            OP_MUL, OP_MULH, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU: is_multi = 1'b1;
            default: alu_res = '0;
        endcase
        signed_op = (Operation == OP_MULH) || (Operation == OP_DIV) || (Operation == OP_REM);
        sign_a    = SrcA[W-1] & signed_op;
        sign_b    = SrcB[W-1] & signed_op;
        mag_a     = sign_a ? -SrcA : SrcA;
        mag_b     = sign_b ? -SrcB : SrcB;
    end

    // One iteration of both datapaths; op_q[2] picks divide over multiply.
    always_comb begin
        sum     = {1'b0, hi_q} + (lo_q[0] ? {1'b0, mcand_q} : {(W+1){1'b0}});
        shifted = {hi_q, lo_q[W-1]};
        ge      = shifted >= {1'b0, mcand_q};
        diff    = shifted[W-1:0] - mcand_q;
        if (op_q[2]) begin
            hi_n = ge ? diff : shifted[W-1:0];
            lo_n = {lo_q[W-2:0], ge};
        end else begin
            hi_n = sum[W:1];
            lo_n = {sum[0], lo_q[W-1:1]};
        end
        prod      = {hi_n, lo_n};
        prod_fix  = neg_quo_q ? -prod : prod;
        quo_fix   = neg_quo_q ? -lo_n : lo_n;
        rem_fix   = neg_rem_q ? -hi_n : hi_n;
        final_res = '0;
        case (op_q)
            OP_MUL:            final_res = prod_fix[W-1:0];
            OP_MULH, OP_MULHU: final_res = prod_fix[2*W-1:W];
            OP_DIV, OP_DIVU:   final_res = dz_q ? {W{1'b1}} : quo_fix;
            OP_REM, OP_REMU:   final_res = dz_q ? src_a_q : rem_fix;
            default:           final_res = '0;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        result_d  = result_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        mcand_d   = mcand_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        src_a_d   = src_a_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        dz_d      = dz_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d      = Operation;
                    src_a_d   = SrcA;
                    dz_d      = (SrcB == '0);
                    neg_quo_d = sign_a ^ sign_b;
                    neg_rem_d = sign_a;
                    hi_d      = '0;
                    if (is_multi) begin
                        state_d = S_BUSY;
                        cnt_d   = CW'(W);
                        mcand_d = Operation[2] ? mag_b : mag_a;
                        lo_d    = Operation[2] ? mag_a : mag_b;
                    end else begin
                        state_d  = S_DONE;
                        result_d = alu_res;
                    end
                end
            end
            S_BUSY: begin
                hi_d  = hi_n;
                lo_d  = lo_n;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d  = S_DONE;
                    result_d = final_res;
                end
            end
            S_DONE: begin
                if (out_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            result_q  <= '0;
            cnt_q     <= '0;
            op_q      <= '0;
            mcand_q   <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            src_a_q   <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            dz_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            result_q  <= result_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            mcand_q   <= mcand_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            src_a_q   <= src_a_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            dz_q      <= dz_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign busy      = (state_q == S_BUSY);
    assign out_valid = (state_q == S_DONE);
    assign ALUResult = result_q;
    assign Zero      = out_valid && (result_q == '0);
endmodule

// File: tb/tb_alu_mdu.sv
// tb/tb_alu_mdu.sv - directed self-checking bench for alu_mdu
module tb_alu_mdu;
    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] SrcA, SrcB;
    logic [4:0]  Operation;
    logic        in_valid, out_ready;
    logic        in_ready, out_valid, busy, Zero;
    logic [31:0] ALUResult;
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alu_mdu #(.DATA_WIDTH(32), .OPCODE_LENGTH(5)) dut (
        .clk(clk), .reset(reset), .SrcA(SrcA), .SrcB(SrcB), .Operation(Operation),
        .in_valid(in_valid), .in_ready(in_ready), .ALUResult(ALUResult), .Zero(Zero),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issues one request from IDLE and waits (bounded) for out_valid; lat counts edges incl. the accept edge.
    task automatic do_req(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int bcnt);
        Operation = op; SrcA = a; SrcB = b; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        lat  = 1;
        bcnt = 0;
        while (!out_valid && lat < 100) begin
            if (busy) bcnt++;
            step();
            lat++;
        end
    endtask

    task automatic release_result();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        SrcA = '0; SrcB = '0; Operation = '0;
        step(); step();
        reset = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || ALUResult !== 32'h0 || Zero !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: got rdy=%b ov=%b busy=%b res=%h z=%b expected 1 0 0 0 0",
                     in_ready, out_valid, busy, ALUResult, Zero);
        end
    endtask

    task automatic test_single();
        logic [4:0]  ops [11] = '{5'b00010, 5'b01100, 5'b01101, 5'b00011, 5'b00000, 5'b00001,
                                 5'b01001, 5'b01000, 5'b01000, 5'b00111, 5'b00010};
        logic [31:0] as  [11] = '{32'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd3, 32'hF0F0_1234, 32'hF0F0_0000,
                                 32'hFF00_FF00, 32'd42, 32'd42, 32'h1234_5678, 32'hFFFFFFFF};
        logic [31:0] bs  [11] = '{32'd7, 32'd1, 32'd1, 32'd3, 32'h0FF0_FF00, 32'h0000_00FF,
                                 32'h0F0F_0F0F, 32'd42, 32'd43, 32'h1, 32'd1};
        logic [31:0] exp [11] = '{32'd12, 32'd1, 32'd0, 32'd0, 32'h00F0_1200, 32'hF0F0_00FF,
                                 32'hF00F_F00F, 32'd1, 32'd0, 32'd0, 32'd0};
        int lat, bcnt;
        for (int i = 0; i < 11; i++) begin
            do_req(ops[i], as[i], bs[i], lat, bcnt);
            checks++;
            if (ALUResult !== exp[i]) begin
                errors++;
                $display("FAIL single_result[%0d]: got %h expected %h", i, ALUResult, exp[i]);
            end
            checks++;
            if (lat !== 1) begin
                errors++;
                $display("FAIL single_latency[%0d]: got %0d expected 1", i, lat);
            end
            checks++;
            if (Zero !== (exp[i] == 32'h0)) begin
                errors++;
                $display("FAIL single_zero[%0d]: got %b expected %b", i, Zero, exp[i] == 32'h0);
            end
            release_result();
        end
    endtask

    task automatic test_multi();
        logic [4:0]  ops [16] = '{5'b10001, 5'b10010, 5'b10000, 5'b10001, 5'b10100, 5'b10110,
                                 5'b10101, 5'b10111, 5'b10100, 5'b10110, 5'b10101, 5'b10111,
                                 5'b10100, 5'b10110, 5'b10100, 5'b10110};
        logic [31:0] as  [16] = '{32'hFFFFFFFF, 32'hFFFFFFFF, 32'h12345678, 32'h80000000, 32'h80000000, 32'h80000000,
                                 32'd100, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF9, 32'd100, 32'd100,
                                 32'd7, 32'd7, 32'hFFFFFFFB, 32'hFFFFFFFB};
        logic [31:0] bs  [16] = '{32'd2, 32'd2, 32'h10, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF,
                                 32'd0, 32'd0, 32'd2, 32'd2, 32'd7, 32'd7,
                                 32'hFFFFFFFE, 32'hFFFFFFFE, 32'd0, 32'd0};
        logic [31:0] exp [16] = '{32'hFFFFFFFF, 32'h1, 32'h23456780, 32'h40000000, 32'h80000000, 32'h0,
                                 32'hFFFFFFFF, 32'd100, 32'hFFFFFFFD, 32'hFFFFFFFF, 32'd14, 32'd2,
                                 32'hFFFFFFFD, 32'd1, 32'hFFFFFFFF, 32'hFFFFFFFB};
        int lat, bcnt;
        for (int i = 0; i < 16; i++) begin
            do_req(ops[i], as[i], bs[i], lat, bcnt);
            checks++;
            if (ALUResult !== exp[i]) begin
                errors++;
                $display("FAIL multi_result[%0d]: got %h expected %h", i, ALUResult, exp[i]);
            end
            checks++;
            if (lat !== 33) begin
                errors++;
                $display("FAIL multi_latency[%0d]: got %0d expected 33", i, lat);
            end
            checks++;
            if (bcnt !== 32) begin
                errors++;
                $display("FAIL multi_busy_cycles[%0d]: got %0d expected 32", i, bcnt);
            end
            release_result();
        end
    endtask

    task automatic test_hold();
        int lat, bcnt;
        do_req(5'b00010, 32'd1, 32'd2, lat, bcnt);
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            Operation = 5'b00010;
            SrcA = 32'h100 + i; SrcB = ~SrcA;
            step();
            checks++;
            if (ALUResult !== 32'd3 || out_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold[%0d]: got res=%h ov=%b rdy=%b expected 3 1 0", i, ALUResult, out_valid, in_ready);
            end
        end
        SrcA = 32'd10; SrcB = 32'd20; out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_release: got rdy=%b ov=%b expected 1 0", in_ready, out_valid);
        end
        step();
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b1 || ALUResult !== 32'd30) begin
            errors++;
            $display("FAIL next_accept: got ov=%b res=%h expected 1 0000001e", out_valid, ALUResult);
        end
        release_result();
    endtask

    task automatic test_reset_busy();
        int seen;
        Operation = 5'b10101; SrcA = 32'd1000; SrcB = 32'd3; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        repeat (9) step();
        checks++;
        if (busy !== 1'b1) begin
            errors++;
            $display("FAIL busy_before_reset: got %b expected 1", busy);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b1 || ALUResult !== 32'h0) begin
            errors++;
            $display("FAIL reset_mid_busy: got ov=%b busy=%b rdy=%b res=%h expected 0 0 1 0",
                     out_valid, busy, in_ready, ALUResult);
        end
        seen = 0;
        repeat (40) begin
            step();
            if (out_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL stale_result: got %0d valid cycles expected 0", seen);
        end
    endtask

    task automatic test_reset_done();
        int lat, bcnt;
        do_req(5'b00010, 32'd1, 32'd1, lat, bcnt);
        reset = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        step();
        reset = 1'b0; out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || ALUResult !== 32'h0 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid_done: got ov=%b res=%h rdy=%b expected 0 0 1", out_valid, ALUResult, in_ready);
        end
        in_valid = 1'b0;
        reset = 1'b1; in_valid = 1'b1; Operation = 5'b00010; SrcA = 32'd9; SrcB = 32'd9;
        step();
        reset = 1'b0; in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || ALUResult !== 32'h0) begin
            errors++;
            $display("FAIL reset_over_accept: got ov=%b rdy=%b res=%h expected 0 1 0", out_valid, in_ready, ALUResult);
        end
        step();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_over_accept_late: got ov=%b expected 0", out_valid);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_multi();
        test_hold();
        test_reset_busy();
        test_reset_done();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_mdu.md
ALU_MDU -- requirements
Module: alu_mdu

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, operand/result width (even, >=8).
REQ-002 SHALL have parameter OPCODE_LENGTH, default 5, Operation width (fixed at 5 for the encodings below).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port SrcA  input  DATA_WIDTH  operand A.
REQ-006 SHALL have port SrcB  input  DATA_WIDTH  operand B.
REQ-007 SHALL have port Operation  input  OPCODE_LENGTH  operation select.
REQ-008 SHALL have port in_valid  input  1  request valid.
REQ-009 SHALL have port in_ready  output  1  block can accept a request.
REQ-010 SHALL have port ALUResult  output  DATA_WIDTH  registered result.
REQ-011 SHALL have port Zero  output  1  high when ALUResult==0, qualified by out_valid.
REQ-012 SHALL have port out_valid  output  1  ALUResult valid.
REQ-013 SHALL have port out_ready  input  1  consumer accepts result.
REQ-014 SHALL have port busy  output  1  high in BUSY state.

Function
REQ-015 SHALL decode single-cycle ops: 00000 AND, 00001 OR, 00010 ADD, 00011 SUB, 01000 EQ (1/0), 01001 XOR, 01100 SLT (signed, 1/0), 01101 SLTU (unsigned, 1/0); add/sub wrap modulo 2^DATA_WIDTH.
REQ-016 SHALL decode multi-cycle ops: 10000 MUL (low half), 10001 MULH (signed x signed, high half), 10010 MULHU (unsigned, high half), 10100 DIV, 10101 DIVU, 10110 REM, 10111 REMU; signed div truncates toward zero, remainder takes dividend sign.
REQ-017 SHALL treat any other Operation code as single-cycle with result 0.
REQ-018 SHALL implement FSM states IDLE, BUSY, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-019 SHALL accept a request on a rising edge where state==IDLE and in_valid==1, capturing SrcA, SrcB, Operation; inputs are ignored outside acceptance.
REQ-020 Single-cycle op: SHALL go IDLE->DONE on the accepting edge; out_valid high after 1 edge.
REQ-021 Multi-cycle op: SHALL go IDLE->BUSY, run an iterative shift-add multiplier or restoring divider for exactly DATA_WIDTH cycles (one bit per cycle, counter DATA_WIDTH..1), then BUSY->DONE; out_valid high DATA_WIDTH+1 edges after the accepting edge, independent of operand values.
REQ-022 Signed ops SHALL operate on magnitudes and fix up sign in the final BUSY cycle; no extra latency.
REQ-023 Divide by zero SHALL give DIV/DIVU = all ones, REM/REMU = SrcA; full latency still applies.
REQ-024 Signed overflow (SrcA = most-negative, SrcB = -1) SHALL give DIV = most-negative, REM = 0.
REQ-025 In DONE, ALUResult and out_valid SHALL hold stable until an edge with out_ready==1, then go to IDLE; no new request is accepted on that same edge.
REQ-026 ALUResult SHALL change only on the edge entering DONE or on reset.

Reset
REQ-027 On a reset edge SHALL go to IDLE from any state: out_valid=0, busy=0, in_ready=1, ALUResult=0, counter=0.
REQ-028 Reset mid-BUSY or mid-DONE SHALL discard the operation with no result presented afterwards.
REQ-029 Reset SHALL override a simultaneous in_valid acceptance or out_ready handshake.

Verification
REQ-030 ADD SrcA=5, SrcB=7, out_ready=1 -> out_valid 1 edge after accept, ALUResult=12, Zero=0.
REQ-031 SLT and SLTU with SrcA=0xFFFFFFFF, SrcB=1 -> 1 and 0; SUB 3-3 -> 0, Zero=1.
REQ-032 MULH and MULHU with 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF and 0x00000001, out_valid exactly 33 edges after accept; busy high 32 cycles.
REQ-033 DIV/REM 0x80000000 by 0xFFFFFFFF -> 0x80000000/0; DIVU/REMU 100 by 0 -> 0xFFFFFFFF/100; DIV -7 by 2 -> -3, REM -> -1.
REQ-034 out_ready held low 5 cycles in DONE with in_valid=1 and operands toggling -> ALUResult stable, in_ready=0; after out_ready edge state IDLE, next request accepted one edge later.
REQ-035 Reset asserted on 10th BUSY cycle of DIVU -> after that edge out_valid=0, busy=0, in_ready=1, ALUResult=0; no stale result later appears.
